// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the R-type control sequencer.
// Holds the state enum, R-type funct codes, ALU control codes and opcode.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/rtype_funct_dec.sv
// Combinational R-type decoder: opcode/funct -> ALU control code + legal flag.
// Ports: i_opcode[5:0], i_funct[5:0] in; o_alu_op[3:0], o_legal out.
// Illegal encodings yield o_alu_op = 0000.
module rtype_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_AND;
    o_legal  = 1'b0;
    if (i_opcode == OP_RTYPE) begin
      case (i_funct)
        FN_ADD: begin o_alu_op = ALU_ADD; o_legal = 1'b1; end
        FN_SUB: begin o_alu_op = ALU_SUB; o_legal = 1'b1; end
        FN_AND: begin o_alu_op = ALU_AND; o_legal = 1'b1; end
        FN_OR:  begin o_alu_op = ALU_OR;  o_legal = 1'b1; end
        FN_NOR: begin o_alu_op = ALU_NOR; o_legal = 1'b1; end
        FN_SLT: begin o_alu_op = ALU_SLT; o_legal = 1'b1; end
        default: begin
          o_alu_op = ALU_AND;
          o_legal  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rtype_ctrl_fsm.sv
// Multi-cycle R-type control sequencer: FETCH -> DECODE -> EXEC -> WB.
// Ports: clk, rst (async, active high); imem_req/imem_ack/imem_data fetch
//   handshake; pc_en PC strobe; rs/rt/rd_addr register addresses;
//   alu_op ALU code; br_we reg write enable; busy; illegal (sticky);
//   fetch_err timeout pulse; retired_cnt retired-instruction counter.
// Config macro HALT_ON_ILLEGAL_EN: illegal instruction parks the FSM in
//   HALT until reset; otherwise it runs as a NOP through EXEC/WB.
module rtype_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic             pc_en,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [3:0]       alu_op,
  output logic             br_we,
  output logic             busy,
  output logic             illegal,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int WAIT_W =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE =
    WAIT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_ir;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_illegal;

  logic       w_ir_ld;
  logic       w_wait_clr;
  logic       w_wait_inc;
  logic       w_retire;
  logic       w_ill_set;
  logic [3:0] w_alu;
  logic       w_legal;
  logic       w_unused;

  rtype_funct_dec u_dec (
    .i_opcode (r_ir[31:26]),
    .i_funct  (r_ir[5:0]),
    .o_alu_op (w_alu),
    .o_legal  (w_legal)
  );

  // shamt is not used by any supported op.
  assign w_unused = ^r_ir[10:6];

  assign rs_addr     = r_ir[25:21];
  assign rt_addr     = r_ir[20:16];
  assign rd_addr     = r_ir[15:11];
  assign illegal     = r_illegal;
  assign retired_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_wait    <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld)
        r_ir <= imem_data;
      if (w_wait_clr)
        r_wait <= '0;
      else if (w_wait_inc)
        r_wait <= r_wait + WAIT_ONE;
      if (w_retire)
        r_cnt <= r_cnt + CNT_ONE;
      if (w_ill_set)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    br_we      = 1'b0;
    fetch_err  = 1'b0;
    busy       = 1'b1;
    alu_op     = ALU_AND;
    w_ir_ld    = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    w_retire   = 1'b0;
    w_ill_set  = 1'b0;
    unique case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_ld    = 1'b1;
          pc_en      = 1'b1;
          w_wait_clr = 1'b1;
          w_next     = DECODE;
        end else if (r_wait == WAIT_LAST) begin
          // Timeout: flag it and retry from a fresh count.
          fetch_err  = 1'b1;
          w_wait_clr = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      DECODE: begin
        w_ill_set = ~w_legal;
`ifdef HALT_ON_ILLEGAL_EN
        w_next = w_legal ? EXEC : HALT;
`else
        w_next = EXEC;
`endif
      end
      EXEC: begin
        alu_op = w_alu;
        w_next = WB;
      end
      WB: begin
        alu_op   = w_alu;
        br_we    = w_legal && (rd_addr != 5'd0);
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      HALT: begin
        busy   = 1'b0;
        w_next = HALT;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_rtype_ctrl_fsm.sv
// Scoreboard bench for rtype_ctrl_fsm: directed instruction words,
// expected per-instruction responses queued and checked by a monitor.
module tb_rtype_ctrl_fsm;

`ifdef HALT_ON_ILLEGAL_EN
  localparam bit HALT_MODE = 1'b1;
`else
  localparam bit HALT_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        imem_req;
  logic        pc_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_op;
  logic        br_we;
  logic        busy;
  logic        illegal;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  rtype_ctrl_fsm #(.CNT_W(32), .ACK_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .pc_en       (pc_en),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .alu_op      (alu_op),
    .br_we       (br_we),
    .busy        (busy),
    .illegal     (illegal),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        we;
    logic        ill;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  bit          model_ill = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] w, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [3:0] alu, input bit legal);
    exp_t e;
    int   k;
    e.halt = !legal && HALT_MODE;
    model_ill = model_ill | !legal;
    if (!e.halt)
      model_cnt++;
    e.rs  = rs;
    e.rt  = rt;
    e.rd  = rd;
    e.alu = alu;
    e.we  = legal && (rd != 5'd0);
    e.ill = model_ill;
    e.cnt = model_cnt;
    sb.push_back(e);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!imem_req && k < 20);
    if (!imem_req) begin
      chk("imem_req_wait", {31'b0, imem_req}, 32'd1);
    end else begin
      imem_data = w;
      imem_ack  = 1'b1;
      @(posedge clk);
      #1;
      // Junk ack while in DECODE must not reload IR.
      imem_data = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      imem_ack  = 1'b0;
      imem_data = '0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk("sb_drain", sb.size(), 32'd0);
    repeat (5) @(posedge clk);
  endtask

  // Monitor: follows each accepted fetch through DECODE/EXEC/WB.
  initial begin
    bit   have;
    exp_t e;
    have = 1'b0;
    forever begin
      if (!have) begin
        @(negedge clk);
        if (!pc_en)
          continue;
      end
      have = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_fetch", 32'd1, 32'd0);
        continue;
      end
      e = sb.pop_front();
      @(negedge clk);
      chk("dec_rs", rs_addr, e.rs);
      chk("dec_rt", rt_addr, e.rt);
      chk("dec_rd", rd_addr, e.rd);
      chk("dec_req", imem_req, 1'b0);
      chk("dec_pc_en", pc_en, 1'b0);
      @(negedge clk);
      chk("ex_illegal", illegal, e.ill);
      chk("ex_br_we", br_we, 1'b0);
      if (e.halt) begin
        chk("halt_busy", busy, 1'b0);
        chk("halt_req", imem_req, 1'b0);
      end else begin
        chk("ex_alu", alu_op, e.alu);
      end
      @(negedge clk);
      if (e.halt) begin
        chk("halt_br_we", br_we, 1'b0);
        chk("halt_busy2", busy, 1'b0);
      end else begin
        chk("wb_br_we", br_we, e.we);
        chk("wb_rd", rd_addr, e.rd);
        chk("wb_alu", alu_op, e.alu);
      end
      @(negedge clk);
      chk("retired", retired_cnt, e.cnt);
      chk("post_br_we", br_we, 1'b0);
      if (e.halt) begin
        chk("halt_req2", imem_req, 1'b0);
        chk("halt_pc_en", pc_en, 1'b0);
      end
      have = pc_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_rs", rs_addr, 5'd0);
    chk("rst_rt", rt_addr, 5'd0);
    chk("rst_rd", rd_addr, 5'd0);
    chk("rst_alu", alu_op, 4'd0);
    chk("rst_br_we", br_we, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ferr", fetch_err, 1'b0);
    chk("rst_cnt", retired_cnt, 32'd0);

    // sub $20,$15,$9 ; add $15,$5,$15 ; add $0,$1,$2
    issue(32'h01E9A022, 5'd15, 5'd9,  5'd20, 4'b0110, 1'b1);
    issue(32'h00AF7820, 5'd5,  5'd15, 5'd15, 4'b0010, 1'b1);
    issue(32'h00220020, 5'd1,  5'd2,  5'd0,  4'b0010, 1'b1);
    // and $3,$4,$5 ; or $6,$7,$8 ; nor $31,$30,$29 ; slt $1,$2,$3
    issue(32'h00851824, 5'd4,  5'd5,  5'd3,  4'b0000, 1'b1);
    issue(32'h00E83025, 5'd7,  5'd8,  5'd6,  4'b0001, 1'b1);
    issue(32'h03DDF827, 5'd30, 5'd29, 5'd31, 4'b1100, 1'b1);
    issue(32'h0043082A, 5'd2,  5'd3,  5'd1,  4'b0111, 1'b1);
    // lw $2,0($1)
    issue(32'h8C220000, 5'd1,  5'd2,  5'd0,  4'b0000, 1'b0);
    drain();

    // Reset while idling in FETCH with the wait counter non-zero.
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_cnt = 0;
    model_ill = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_req", imem_req, 1'b1);
    chk("mid_rst_ill", illegal, 1'b0);
    chk("mid_rst_cnt", retired_cnt, 32'd0);
    chk("mid_rst_ferr", fetch_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("tmo_ferr_c%0d", c), fetch_err, (c == 8));
      chk($sformatf("tmo_req_c%0d", c), imem_req, 1'b1);
      chk($sformatf("tmo_pc_en_c%0d", c), pc_en, 1'b0);
    end
    // Ack in cycle 10 after the timeout.
    issue(32'h01E9A022, 5'd15, 5'd9, 5'd20, 4'b0110, 1'b1);
    // add with unsupported funct 0x21
    issue(32'h00430821, 5'd2, 5'd3, 5'd1, 4'b0000, 1'b0);
    if (!HALT_MODE)
      issue(32'h00AF7820, 5'd5, 5'd15, 5'd15, 4'b0010, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
